// File: rtl/alu_operand_mux.sv
// alu_operand_mux
//   Registered N-channel operand selector feeding the ALU input register.
//   One channel is granted per cycle, either by explicit index (mode=0) or
//   round-robin among valid channels (mode=1). The granted word is captured
//   in a single output slot with a valid/ready handshake on both sides.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    CHANNELS*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   sel        channel index used in explicit mode
//   mode       0 = explicit select, 1 = round-robin
//   out_data   registered selected word
//   out_chan   index of the channel that produced out_data
//   out_valid  output slot holds an untaken word
//   out_ready  downstream accepts the word
module alu_operand_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SEL_W-1:0]    rr_ptr;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic                grant_any;
    logic [WIDTH-1:0]    grant_data;
    logic                can_load;
    logic                xfer;
    logic [SEL_W-1:0]    ptr_next;

    assign can_load = ~out_valid | out_ready;

    // Round-robin scan is split into two passes: channels at or above rr_ptr
    // first, then the ones below it. That is the wrap-around search without
    // any modulo arithmetic on the index. An out-of-range sel never matches.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (!mode) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (SEL_W'(i) == sel && in_valid[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = SEL_W'(i);
                    grant_any = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!grant_any && in_valid[i] && SEL_W'(i) >= rr_ptr) begin
                    grant[i]  = 1'b1;
                    grant_idx = SEL_W'(i);
                    grant_any = 1'b1;
                end
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (!grant_any && in_valid[i] && SEL_W'(i) < rr_ptr) begin
                    grant[i]  = 1'b1;
                    grant_idx = SEL_W'(i);
                    grant_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // rst_n gates ready directly so nothing is offered while reset is held.
    assign in_ready = grant & {CHANNELS{can_load & rst_n}};
    assign xfer     = grant_any & can_load;
    assign ptr_next = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_data  <= grant_data;
            out_chan  <= grant_idx;
            out_valid <= 1'b1;
            if (mode) begin
                rr_ptr <= ptr_next;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_operand_mux.md
Name: alu_operand_mux

Overview:
- Parametrised, registered N-channel operand selector for the ALU datapath; generalises the fixed 8-bit 2:1 select into CHANNELS inputs of WIDTH bits.
- Each input channel and the output use a valid/ready handshake.
- Two selection modes: explicit select (sel port) and round-robin among valid channels.
- Sits between operand sources (register file, immediate, forwarding paths) and the ALU input register. Drives one ALU operand per transfer.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, 2, select/channel-index width; must satisfy 2**SEL_W >= CHANNELS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; combinational.
- sel  input  SEL_W  channel index used when mode=0.
- mode  input  1  0 = explicit select, 1 = round-robin.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output holds an untaken word.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset (rst_n low, asynchronous): out_data=0, out_chan=0, out_valid=0, rr_ptr=0.
  - in_ready is all zero while rst_n is low.
  - A word held at reset is discarded; there is no replay.
- Output slot:
  - Single register stage; latency 1 cycle from input transfer to out_valid.
  - Full throughput of 1 word/cycle when out_ready is held high.
- can_load = ~out_valid | out_ready.
- Grant (combinational, at most one bit set):
  - mode=0:
    - grant[sel]=1 only if sel<CHANNELS and in_valid[sel].
    - sel>=CHANNELS grants nothing. No transfer occurs and no error is raised.
  - mode=1:
    - Scan channels starting at rr_ptr, upward with wrap modulo CHANNELS.
    - Grant the first channel with in_valid=1.
    - No channel valid: no grant.
- in_ready[i] = grant[i] & can_load & rst_n. Non-granted channels see in_ready=0.
- Input transfer (in_valid[i] & in_ready[i]):
  - out_data <= channel i data.
  - out_chan <= i.
  - out_valid <= 1.
- Output transfer without a new input: out_valid <= 0. out_data and out_chan hold their last values.
- Simultaneous output take and input transfer in the same cycle: the slot reloads, out_valid stays 1, and there is no bubble.
- Backpressure: while out_valid & ~out_ready, out_data and out_chan must stay stable and all in_ready=0.
- rr_ptr:
  - Advances only on an input transfer in mode=1, to (granted index + 1) mod CHANNELS; the wrap is from CHANNELS-1 to 0.
  - Unchanged in mode=0.
  - mode may change on any cycle; it takes effect on that cycle's grant, and rr_ptr is preserved across mode changes.
- Inputs must hold data/valid until accepted. The block does not check this.
- No internal storage beyond the output slot and rr_ptr.

Test Plan:
- Reset, then mode=0, sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1.
  - Required: in_ready=4'b0100 in the same cycle.
  - Next cycle: out_valid=1, out_data=8'hA5, out_chan=2.
- mode=1, all four channels valid (data 8'h10, 8'h11, 8'h12, 8'h13), out_ready=1 for 6 cycles.
  - Required: out_chan sequence 0,1,2,3,0,1; out_data 8'h10..8'h13, then 8'h10, 8'h11; out_valid continuously 1 with no bubbles.
- mode=1, in_valid=4'b1001, rr_ptr=1.
  - Required: grant ch3, then rr_ptr wraps to 0 and ch0 is granted; out_chan sequence 3,0,3,0.
- Backpressure: output holding 8'h5A, out_ready=0 for 3 cycles with ch1 valid.
  - Required: out_data stays 8'h5A, in_ready=0 throughout.
  - out_ready rises: the same cycle shows in_ready[1]=1 and the next word loads with no gap.
- mode=0, sel=3 with CHANNELS=3 (SEL_W=2), all in_valid=1.
  - Required: in_ready=0, out_valid falls after the pending word drains, no transfer.
- Reset mid-operation: rst_n low for 1 cycle while out_valid=1, out_data=8'hFF.
  - Required: asynchronously out_valid=0, out_data=0, out_chan=0, in_ready=0.
  - After release in mode=1: the first grant starts from ch0.
